// File: rtl/irq_encoder_16_if.sv
// Request/grant bundle between the interrupt sources, the control unit and irq_encoder_16.
// The master side drives the requests and the handshake. The slave side is the encoder.
interface irq_encoder_16_if;
  logic        Enable;
  logic [15:0] Req;
  logic [15:0] Mask;
  logic        Ack;
  logic        Valid;
  logic [3:0]  Index;
  logic [15:0] Pending;

  modport master (
    output Enable, Req, Mask, Ack,
    input  Valid, Index, Pending
  );

  modport slave (
    input  Enable, Req, Mask, Ack,
    output Valid, Index, Pending
  );
endinterface

// File: rtl/irq_encoder_16.sv
// Registered 16-to-4 priority encoder. It captures requests into a pending register and
// presents the lowest-numbered unmasked pending line through a valid/ack handshake.
module irq_encoder_16 #(
  parameter bit EDGE = 1'b1
) (
  input logic             Clock,
  input logic             nReset,
  irq_encoder_16_if.slave bus
);

  typedef enum logic {StIdle, StPresent} state_e;

  state_e      state_q, state_d;
  logic [15:0] req_prev_q;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  index_q, index_d;

  logic [15:0] set;
  logic [15:0] clr;
  logic [15:0] cand;
  logic [3:0]  enc;

  always_comb begin
    set = EDGE ? (bus.Req & ~req_prev_q) : bus.Req;
    clr = '0;
    if (state_q == StPresent && bus.Ack) begin
      clr[index_q] = 1'b1;
    end
    // A new event in the same cycle as its ack survives.
    pending_d = set | (pending_q & ~clr);
  end

  // Candidates come from the registered pending bits only, so there is no input-to-grant path.
  always_comb begin
    cand = pending_q & ~bus.Mask;
    enc  = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (cand[i]) begin
        enc = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Enable && (cand != 16'h0000)) begin
          index_d = enc;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (bus.Ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      req_prev_q <= '0;
      pending_q  <= '0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= bus.Req;
      pending_q  <= pending_d;
      index_q    <= index_d;
    end
  end

  assign bus.Valid   = (state_q == StPresent);
  assign bus.Index   = index_q;
  assign bus.Pending = pending_q;

endmodule

// File: tb/tb_irq_encoder_16.sv
// Bench for irq_encoder_16. It runs an edge-mode and a level-mode instance side by side and
// checks both against a cycle-level reference model, using directed and random stimulus.
module tb_irq_encoder_16;

  logic Clock;
  logic nReset;

  irq_encoder_16_if bus_e ();
  irq_encoder_16_if bus_l ();

  irq_encoder_16 #(.EDGE(1'b1)) dut_e (.Clock(Clock), .nReset(nReset), .bus(bus_e));
  irq_encoder_16 #(.EDGE(1'b0)) dut_l (.Clock(Clock), .nReset(nReset), .bus(bus_l));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic [15:0] prev;
    logic [15:0] pend;
    logic [3:0]  idx;
    bit          present;
  } model_t;

  model_t m_e, m_l;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.prev = '0;
    r.pend = '0;
    r.idx = '0;
    r.present = 1'b0;
    return r;
  endfunction

  // One clock of behaviour, derived from the capture, clear and grant rules.
  function automatic model_t model_next(model_t m, bit edge_mode, logic en, logic [15:0] req,
                                        logic [15:0] mask, logic ack);
    model_t n = m;
    logic [15:0] cand = m.pend & ~mask;
    for (int i = 0; i < 16; i++) begin
      bit s = edge_mode ? (req[i] && !m.prev[i]) : req[i];
      bit c = m.present && ack && (int'(m.idx) == i);
      n.pend[i] = s || (m.pend[i] && !c);
    end
    n.prev = req;
    if (!m.present) begin
      if (en && cand != 0) begin
        int k = 0;
        while (!cand[k]) k++;
        n.idx = 4'(k);
        n.present = 1'b1;
      end
    end else if (ack) begin
      n.present = 1'b0;
    end
    return n;
  endfunction

  task automatic check_all();
    check_eq("e_valid", 32'(bus_e.Valid), 32'(m_e.present));
    check_eq("e_index", 32'(bus_e.Index), 32'(m_e.idx));
    check_eq("e_pending", 32'(bus_e.Pending), 32'(m_e.pend));
    check_eq("l_valid", 32'(bus_l.Valid), 32'(m_l.present));
    check_eq("l_index", 32'(bus_l.Index), 32'(m_l.idx));
    check_eq("l_pending", 32'(bus_l.Pending), 32'(m_l.pend));
  endtask

  task automatic drive(input logic en, input logic [15:0] req, input logic [15:0] mask,
                       input logic ack);
    bus_e.Enable = en;
    bus_e.Req = req;
    bus_e.Mask = mask;
    bus_e.Ack = ack;
    bus_l.Enable = en;
    bus_l.Req = req;
    bus_l.Mask = mask;
    bus_l.Ack = ack;
  endtask

  task automatic step(input logic en, input logic [15:0] req, input logic [15:0] mask,
                      input logic ack);
    model_t ne, nl;
    drive(en, req, mask, ack);
    ne = model_next(m_e, 1'b1, en, req, mask, ack);
    nl = model_next(m_l, 1'b0, en, req, mask, ack);
    @(posedge Clock);
    #1;
    m_e = ne;
    m_l = nl;
    check_all();
  endtask

  initial begin
    nReset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    m_e = model_reset();
    m_l = model_reset();
    #3;
    check_all();
    #9 nReset = 1'b1;

    // Single request on line 5.
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 16'h0020, 16'h0000, 1'b0);
    check_eq("single_pend", 32'(bus_e.Pending), 32'h0020);
    check_eq("single_novalid", 32'(bus_e.Valid), 32'h0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_eq("single_valid", 32'(bus_e.Valid), 32'h1);
    check_eq("single_index", 32'(bus_e.Index), 32'd5);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    check_eq("single_ack_valid", 32'(bus_e.Valid), 32'h0);
    check_eq("single_ack_pend", 32'(bus_e.Pending), 32'h0);

    // Priority with line 3 masked, then unmasked.
    step(1'b1, 16'h1208, 16'h0008, 1'b0);
    step(1'b1, 16'h0000, 16'h0008, 1'b0);
    check_eq("prio_first", 32'(bus_e.Index), 32'd9);
    step(1'b1, 16'h0000, 16'h0008, 1'b1);
    step(1'b1, 16'h0000, 16'h0008, 1'b0);
    check_eq("prio_second", 32'(bus_e.Index), 32'd12);
    step(1'b1, 16'h0000, 16'h0008, 1'b1);
    check_eq("prio_masked_pend", 32'(bus_e.Pending), 32'h0008);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_eq("prio_unmasked", 32'(bus_e.Index), 32'd3);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // No preemption, then set wins over clear on line 7.
    step(1'b1, 16'h0080, 16'h0000, 1'b0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 16'h0001, 16'h0000, 1'b0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_eq("nopreempt", 32'(bus_e.Index), 32'd7);
    step(1'b1, 16'h0080, 16'h0000, 1'b1);
    check_eq("setwins", 32'(bus_e.Pending), 32'h0081);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_eq("next_is_0", 32'(bus_e.Index), 32'd0);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_eq("regrant_7", 32'(bus_e.Index), 32'd7);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // Enable gating, and an ack while idle does nothing.
    step(1'b0, 16'h0004, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check_eq("gated_valid", 32'(bus_e.Valid), 32'h0);
    check_eq("gated_pend", 32'(bus_e.Pending), 32'h0004);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_eq("enabled_index", 32'(bus_e.Index), 32'd2);
    step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // Level mode: hold line 4, ack every grant, then drop it.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0010, 16'h0000, bus_l.Valid);
    step(1'b1, 16'h0000, 16'h0000, bus_l.Valid);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0000, 16'h0000, bus_l.Valid);
    check_eq("level_drained", 32'(bus_l.Pending), 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r, k;
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      k = 16'($urandom) & 16'($urandom);
      step(($urandom % 4) != 0, r, k, 1'($urandom));
    end
    drive(1'b1, '0, '0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 16'h0000, 16'h0000, 1'b1);

    // Asynchronous reset while a grant is presented.
    step(1'b1, 16'h0101, 16'h0000, 1'b0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0);
    check_eq("pre_rst_valid", 32'(bus_e.Valid), 32'h1);
    check_eq("pre_rst_pend", 32'(bus_e.Pending), 32'h0101);
    #2 nReset = 1'b0;
    #1;
    m_e = model_reset();
    m_l = model_reset();
    check_eq("rst_valid", 32'(bus_e.Valid), 32'h0);
    check_eq("rst_index", 32'(bus_e.Index), 32'h0);
    check_eq("rst_pend", 32'(bus_e.Pending), 32'h0);
    check_all();
    drive(1'b1, 16'h0400, 16'h0000, 1'b0);
    #3 nReset = 1'b1;
    step(1'b1, 16'h0400, 16'h0000, 1'b0);
    check_eq("post_rst_capture", 32'(bus_e.Pending), 32'h0400);
    step(1'b1, 16'h0400, 16'h0000, 1'b0);
    step(1'b1, 16'h0400, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0400, 16'h0000, 1'b0);
    check_eq("post_rst_once", 32'(bus_e.Pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
